// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg: shared lock-FSM state encoding and parameter defaults for serial_paralelo_sync
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sp_state_t;

    localparam int         SP_DATA_W   = 8;
    localparam logic [7:0] SP_COMMA    = 8'hBC;
    localparam int         SP_LOCK_CNT = 4;
    localparam int         SP_LOSS_CNT = 2;

endpackage

// File: rtl/serial_paralelo_sync_sp_shift_window.sv
// sp_shift_window: serial shift register and bit counter producing the current word window and boundary flags
// Ports:
//   i_clk, i_rst_n     bit clock, asynchronous active-low reset
//   i_bit, i_valid     serial bit (MSB first) and stream-valid qualifier
//   i_realign          force the current cycle to be a word end (comma found while searching)
//   o_window           {previous DATA_W-1 bits, i_bit}
//   o_comma_hit        window equals COMMA on a valid cycle
//   o_word_end         valid cycle on which the bit counter is at DATA_W-1
module sp_shift_window #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] COMMA  = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bit,
    input  logic              i_valid,
    input  logic              i_realign,
    output logic [DATA_W-1:0] o_window,
    output logic              o_comma_hit,
    output logic              o_word_end
);

    localparam int BW = $clog2(DATA_W);

    // Only the DATA_W-1 older bits are stored; the newest bit comes straight from the line.
    logic [DATA_W-2:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;

    assign o_window    = {r_shreg, i_bit};
    assign o_comma_hit = i_valid && (o_window == COMMA);
    assign o_word_end  = i_valid && (r_bit_cnt == BW'(DATA_W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (!i_valid) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_shreg   <= o_window[DATA_W-2:0];
            r_bit_cnt <= (i_realign || o_word_end) ? '0 : r_bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync: serial-to-parallel converter with comma alignment and lock FSM on the bit clock
// Ports:
//   clk_32f        serial bit clock (rising edge)
//   reset_L        asynchronous active-low reset
//   data_input     serial bit, MSB first
//   valid_in       stream valid; low clears alignment and returns to SEARCH
//   data_output    last completed word (held when no new word)
//   data_valid     one-cycle strobe when data_output updates
//   active_output  high while word lock is held
//   BC_contador    consecutive aligned comma count, saturating at LOCK_CNT
// Build option: SERIAL_PARALELO_COMMA_DROP_EN strips aligned commas from the output while locked.
module serial_paralelo_sync
    import serial_paralelo_pkg::*;
#(
    parameter int                DATA_W   = SP_DATA_W,
    parameter logic [DATA_W-1:0] COMMA    = DATA_W'(SP_COMMA),
    parameter int                LOCK_CNT = SP_LOCK_CNT,
    parameter int                LOSS_CNT = SP_LOSS_CNT,
    localparam int               CNT_W    = $clog2(LOCK_CNT + 1)
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_input,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_output,
    output logic              data_valid,
    output logic              active_output,
    output logic [CNT_W-1:0]  BC_contador
);

    localparam int MW = $clog2(LOSS_CNT + 1);
`ifdef SERIAL_PARALELO_COMMA_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    sp_state_t         r_state, w_state_n;
    logic [CNT_W-1:0]  r_bc, w_bc_n;
    logic [MW-1:0]     r_miss, w_miss_n;
    logic [DATA_W-1:0] r_data;
    logic              r_dv, r_active, w_load;
    logic [DATA_W-1:0] w_window;
    logic              w_comma_hit, w_word_end;

    sp_shift_window #(.DATA_W(DATA_W), .COMMA(COMMA)) u_win (
        .i_clk       (clk_32f),
        .i_rst_n     (reset_L),
        .i_bit       (data_input),
        .i_valid     (valid_in),
        .i_realign   (r_state == SEARCH && w_comma_hit),
        .o_window    (w_window),
        .o_comma_hit (w_comma_hit),
        .o_word_end  (w_word_end)
    );

    always_comb begin
        w_state_n = r_state;
        w_bc_n    = r_bc;
        w_miss_n  = r_miss;
        w_load    = 1'b0;
        if (!valid_in) begin
            w_state_n = SEARCH;
            w_bc_n    = '0;
            w_miss_n  = '0;
        end else begin
            case (r_state)
                SEARCH: if (w_comma_hit) begin
                    w_bc_n    = CNT_W'(1);
                    w_state_n = (LOCK_CNT == 1) ? LOCKED : ALIGN;
                end
                ALIGN: if (w_word_end) begin
                    w_bc_n    = w_comma_hit ? r_bc + 1'b1 : '0;
                    w_state_n = !w_comma_hit ? SEARCH :
                                (r_bc == CNT_W'(LOCK_CNT - 1)) ? LOCKED : ALIGN;
                end
                LOCKED: begin
                    w_load = w_word_end && !(DROP && w_comma_hit);
                    // An aligned comma is never a misalignment; it re-arms the loss counter.
                    if (w_comma_hit && w_word_end)
                        w_miss_n = '0;
                    else if (w_comma_hit && r_miss == MW'(LOSS_CNT - 1)) begin
                        w_state_n = SEARCH;
                        w_bc_n    = '0;
                        w_miss_n  = '0;
                    end else if (w_comma_hit)
                        w_miss_n = r_miss + 1'b1;
                end
                default: w_state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= SEARCH;
            r_bc     <= '0;
            r_miss   <= '0;
            r_data   <= '0;
            r_dv     <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_bc     <= w_bc_n;
            r_miss   <= w_miss_n;
            r_data   <= w_load ? w_window : r_data;
            r_dv     <= w_load;
            r_active <= (w_state_n == LOCKED);
        end
    end

    assign data_output   = r_data;
    assign data_valid    = r_dv;
    assign active_output = r_active;
    assign BC_contador   = r_bc;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb_serial_paralelo_sync: table-driven directed bench for serial_paralelo_sync (8-bit default and 10-bit instances)
module tb_serial_paralelo_sync;

`ifdef SERIAL_PARALELO_COMMA_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       d_a = 1'b0, v_a = 1'b0, d_b = 1'b0, v_b = 1'b0;
    logic [7:0] do_a;
    logic       dv_a, act_a;
    logic [2:0] bc_a;
    logic [9:0] do_b;
    logic       dv_b, act_b;
    logic [1:0] bc_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_paralelo_sync dut_a (
        .clk_32f(clk), .reset_L(reset_L), .data_input(d_a), .valid_in(v_a),
        .data_output(do_a), .data_valid(dv_a), .active_output(act_a), .BC_contador(bc_a)
    );

    serial_paralelo_sync #(.DATA_W(10), .COMMA(10'h17C), .LOCK_CNT(2)) dut_b (
        .clk_32f(clk), .reset_L(reset_L), .data_input(d_b), .valid_in(v_b),
        .data_output(do_b), .data_valid(dv_b), .active_output(act_b), .BC_contador(bc_b)
    );

    typedef struct {
        bit         sel;
        logic [9:0] w;
        logic [9:0] edo;
        bit         edv;
        bit         eact;
        logic [2:0] ebc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, logic [9:0] w, logic [9:0] edo, bit edv, bit eact, logic [2:0] ebc);
        vec_t v;
        v.sel = s; v.w = w; v.edo = edo; v.edv = edv; v.eact = eact; v.ebc = ebc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [9:0] w, output int strobes);
        strobes = 0;
        for (int i = (sel ? 9 : 7); i >= 0; i--) begin
            if (sel) begin d_b = w[i]; v_b = 1'b1; end
            else begin d_a = w[i]; v_a = 1'b1; end
            tick();
            strobes += int'(sel ? dv_b : dv_a);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        int st;
        for (int i = lo; i <= hi; i++) begin
            send(vecs[i].sel, vecs[i].w, st);
            chk($sformatf("v%0d data_output", i), vecs[i].sel ? do_b : {2'b00, do_a}, vecs[i].edo);
            chk($sformatf("v%0d data_valid", i), vecs[i].sel ? dv_b : dv_a, vecs[i].edv);
            chk($sformatf("v%0d strobes", i), st, vecs[i].edv);
            chk($sformatf("v%0d active_output", i), vecs[i].sel ? act_b : act_a, vecs[i].eact);
            chk($sformatf("v%0d BC_contador", i), vecs[i].sel ? {1'b0, bc_b} : bc_a, vecs[i].ebc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        // acquisition from a 3-bit misaligned start, then data and commas
        vecs.push_back(mk(0, 10'h0BC, 10'h000, 0, 0, 1));
        vecs.push_back(mk(0, 10'h0BC, 10'h000, 0, 0, 2));
        vecs.push_back(mk(0, 10'h0BC, 10'h000, 0, 0, 3));
        vecs.push_back(mk(0, 10'h0BC, 10'h000, 0, 1, 4));
        vecs.push_back(mk(0, 10'h05A, 10'h05A, 1, 1, 4));
        vecs.push_back(mk(0, 10'h0C3, 10'h0C3, 1, 1, 4));
        vecs.push_back(mk(0, 10'h0BC, DROP ? 10'h0C3 : 10'h0BC, !DROP, 1, 4));
        vecs.push_back(mk(0, 10'h011, 10'h011, 1, 1, 4));
        vecs.push_back(mk(0, 10'h0BC, DROP ? 10'h011 : 10'h0BC, !DROP, 1, 4));
        vecs.push_back(mk(0, 10'h022, 10'h022, 1, 1, 4));
        // 3-bit slip: 000+BC+BC regrouped on the old boundary; 2nd misaligned comma drops lock
        vecs.push_back(mk(0, 10'h017, 10'h017, 1, 1, 4));
        vecs.push_back(mk(0, 10'h097, 10'h097, 1, 1, 4));
        vecs.push_back(mk(0, 10'h080, 10'h097, 0, 0, 0));
        // broken alignment
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 0, 1));
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 0, 2));
        vecs.push_back(mk(0, 10'h000, 10'h097, 0, 0, 0));
        // reacquire
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 0, 1));
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 0, 2));
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 0, 3));
        vecs.push_back(mk(0, 10'h0BC, 10'h097, 0, 1, 4));
        vecs.push_back(mk(0, 10'h05A, 10'h05A, 1, 1, 4));
        // after valid_in drop
        vecs.push_back(mk(0, 10'h0BC, 10'h05A, 0, 0, 1));
        // 10-bit instance, LOCK_CNT=2
        vecs.push_back(mk(1, 10'h17C, 10'h000, 0, 0, 1));
        vecs.push_back(mk(1, 10'h17C, 10'h000, 0, 1, 2));
        vecs.push_back(mk(1, 10'h2A5, 10'h2A5, 1, 1, 2));
        vecs.push_back(mk(1, 10'h17C, DROP ? 10'h2A5 : 10'h17C, !DROP, 1, 2));

        // reset held with a live random stream: everything stays zero
        #2 reset_L = 1'b0;
        v_a = 1'b1;
        v_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_a = 1'($urandom);
            d_b = 1'($urandom);
            tick();
            chk("reset A outputs", {do_a, dv_a, act_a, bc_a}, 0);
            chk("reset B outputs", {do_b, dv_b, act_b, bc_b}, 0);
        end
        reset_L = 1'b1;
        d_a = 1'b0;
        v_b = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        apply(0, 20);

        // valid_in low for one cycle halfway through a word while locked
        for (int i = 0; i < 4; i++) begin
            d_a = (i < 2);
            tick();
            chk("pre-drop strobe", dv_a, 0);
        end
        chk("pre-drop active", act_a, 1);
        v_a = 1'b0;
        tick();
        chk("drop active", act_a, 0);
        chk("drop data_valid", dv_a, 0);
        chk("drop data_output", do_a, 8'h5A);
        chk("drop BC", bc_a, 0);
        apply(21, 21);
        v_a = 1'b0;

        for (int i = 0; i < 3; i++) begin
            d_b = 1'b0;
            v_b = 1'b1;
            tick();
        end
        apply(22, 25);

        send(1, 10'h3FF, st);
        chk("B idle data word strobes", st, 1);
        chk("B idle data word value", do_b, 10'h3FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_sync.md
# serial_paralelo_sync

Parametrised serial-to-parallel converter with comma-based word alignment and a lock state machine. It runs entirely on the serial bit clock and derives word boundaries from an internal bit counter, so no second word-rate clock is needed. It sits in phy_rx behind the line deserialiser input and feeds the receive-side word path. `active_output` stays high only while the block holds word lock.

## Interface
- `DATA_W`, 8: word width in bits; minimum 4.
- `COMMA`, 8'hBC: alignment/idle word, `DATA_W` bits.
- `LOCK_CNT`, 4: consecutive aligned commas required to enter LOCKED; minimum 1.
- `LOSS_CNT`, 2: consecutive misaligned commas that drop lock; minimum 1.
- `CNT_W`, $clog2(LOCK_CNT+1): width of `BC_contador` (localparam).

- `clk_32f` input 1: serial bit clock. All logic is on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `data_input` input 1: serial bit. The first bit received is the MSB of the word.
- `valid_in` input 1: the serial stream is valid; low means the line is idle or invalid.
- `data_output` output DATA_W: last completed word.
- `data_valid` output 1: one-cycle strobe when `data_output` updates with a word for downstream use.
- `active_output` output 1: high in LOCKED.
- `BC_contador` output CNT_W: count of consecutive aligned commas, saturating at LOCK_CNT.

## Operation
- Shift register `shreg[DATA_W-1:0]` shifts left each valid cycle. The current window is {shreg[DATA_W-2:0], data_input}.
- Bit counter `bit_cnt` runs 0..DATA_W-1 and wraps to 0. A word completes on a cycle where `bit_cnt`==DATA_W-1.
- **SEARCH**
  - The window is compared against COMMA on every valid cycle.
  - On a match: `bit_cnt`←0 (the match cycle is treated as a word end), `BC_contador`←1, go to ALIGN. If LOCK_CNT==1, go straight to LOCKED.
  - `data_valid` stays 0.
- **ALIGN**
  - At each word end: if window==COMMA, `BC_contador`+1. Reaching LOCK_CNT → LOCKED.
  - If window≠COMMA: `BC_contador`←0 and go back to SEARCH.
  - `data_valid` stays 0.
- **LOCKED**
  - At each word end: `data_output`←window and `data_valid`=1.
  - A COMMA match at a non-boundary position (`bit_cnt`≠DATA_W-1) increments the misalignment counter.
  - An aligned comma clears the misalignment counter.
  - When the misalignment counter reaches LOSS_CNT: go to SEARCH, `BC_contador`←0.
- **`valid_in` low, any state**
  - No bit is sampled. `shreg`, `bit_cnt`, `BC_contador` and the misalignment counter clear; the state goes to SEARCH.
  - `data_output` holds its value; `data_valid`=0.
- **Simultaneous events**
  - `valid_in` low takes priority over all other transitions.
  - In LOCKED, an aligned comma at a word end is output normally (unless filtered, see Configuration) and is never counted as misaligned.
- Counter widths: `BC_contador` saturates at LOCK_CNT and never wraps. The misalignment counter is $clog2(LOSS_CNT+1) bits and saturates.

## Timing
- Reset values: `data_output`=0, `data_valid`=0, `active_output`=0, `BC_contador`=0, state SEARCH, `shreg`=0, `bit_cnt`=0.
- Deasserting `reset_L` takes effect on the next rising edge.
- Latency: the word is registered on the same edge that samples its last bit, so `data_output` and `data_valid` are visible in the following cycle.
- `data_valid` is at most one cycle per DATA_W cycles.
- `active_output` is registered:
  - rises on the edge where the state enters LOCKED;
  - falls on the edge where the state leaves LOCKED.
- Lock acquisition takes at least LOCK_CNT·DATA_W cycles from the first comma bit.
- A reset asserted mid-word discards the partial word; no strobe is issued.

## Configuration
- `SERIAL_PARALELO_COMMA_DROP_EN`
  - **Defined:** in LOCKED, aligned COMMA words do not update `data_output` and do not assert `data_valid`. Idle commas are stripped.
  - **Undefined:** commas pass through like any other word, with `data_valid`=1.
- Lock and misalignment behaviour is identical in both builds.

## Structure
- Package `serial_paralelo_pkg`:
  - state encoding SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2;
  - default COMMA constant 8'hBC;
  - shared parameter defaults.
- Sub-module `sp_shift_window`:
  - contains the shift register, `bit_cnt`, the window output and `comma_hit`/`word_end` flags;
  - handles `valid_in` clearing.
- The top level holds the FSM, counters and output registers.

## Test plan
All scenarios use the defaults unless stated.

- **Reset:** hold `reset_L`=0 with `valid_in`=1 and random bits → all outputs stay 0 and the state is SEARCH. Release, send 4 aligned 0xBC → `active_output` rises on the 32nd bit edge and `BC_contador` steps 1,2,3,4.
- **Misaligned start:** 3 random bits, then 4×0xBC, then 0x5A, 0xC3 → lock reached. Outputs are 0x5A then 0xC3, each with a one-cycle `data_valid` 8 cycles apart, MSB first. In the non-DROP build 0xBC also appears on `data_output` after lock.
- **Broken alignment:** 2×0xBC, then 0x00 → `BC_contador` returns to 0, state SEARCH, `active_output` never rises.
- **Loss of lock:** once locked, slip the stream by 3 bits so two commas land off-boundary → `active_output` falls after the second misaligned comma, and `BC_contador`=0.
- **`valid_in` drop:** pull `valid_in` low for 1 cycle mid-word while locked → state SEARCH, `data_output` holds, no `data_valid`, `active_output` falls next edge.
- **Configuration and width:** with `SERIAL_PARALELO_COMMA_DROP_EN` defined, send 0xBC,0x11,0xBC,0x22 after lock → only 0x11 and 0x22 are strobed. Repeat the acquisition test with DATA_W=10, COMMA=10'h17C, LOCK_CNT=2.
